// File: rtl/out_port_fifo.sv
// Output port FIFO: bus words captured on load are queued for a valid/ready consumer.
// State updates on the falling clock edge, matching the other bus-loaded registers.
module out_port_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] or_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] or_out_q, or_out_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign or_out    = or_out_q;
  assign overflow  = overflow_q;
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;

  // A full FIFO still accepts a load when the head leaves on the same edge.
  assign pop  = out_valid && out_ready;
  assign push = load && (!full || pop);
  assign drop = load && !push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    or_out_d   = or_out_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      or_out_d = bus;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // Set beats clear so a drop on the clearing edge is not lost.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      or_out_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      or_out_q   <= or_out_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(negedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus;
    end
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo: reset, fill/drain, overflow, full push+pop, wrap, latency.
module tb_out_port_fifo;

  logic        clk = 1'b1;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bus = '0;
  logic [15:0] or_out, out_data;
  logic        out_valid, out_ready = 1'b0;
  logic        full, overflow, clr_ovf = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  out_port_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .bus       (bus),
    .or_out    (or_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  // Drive inputs, let one falling edge pass, then leave time to sample.
  task automatic tick(input logic l, input logic [15:0] b, input logic r, input logic c);
    load = l; bus = b; out_ready = r; clr_ovf = c;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    load = 0; out_ready = 0; clr_ovf = 0; bus = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic fill4();
    tick(1, 16'h1111, 0, 0);
    tick(1, 16'h2222, 0, 0);
    tick(1, 16'h3333, 0, 0);
    tick(1, 16'h4444, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || full !== 1'b0 || out_data !== 16'h0 ||
        or_out !== 16'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: count=%0d valid=%b full=%b data=%h or=%h ovf=%b, need 0",
               count, out_valid, full, out_data, or_out, overflow);
    end
    tick(1, 16'hA5A5, 0, 0);
    tick(1, 16'h5A5A, 0, 0);
    checks++;
    if (count !== 3'd2 || or_out !== 16'h5A5A) begin
      errors++;
      $display("FAIL reset_pre: count=%0d or=%h, need 2 5a5a", count, or_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0 || or_out !== 16'h0 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: count=%0d valid=%b data=%h or=%h ovf=%b, need 0",
               count, out_valid, out_data, or_out, overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [15:0] heads [3];
    heads[0] = 16'h2222; heads[1] = 16'h3333; heads[2] = 16'h4444;
    do_reset();
    fill4();
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || or_out !== 16'h4444 || out_data !== 16'h1111) begin
      errors++;
      $display("FAIL fill: full=%b count=%0d or=%h data=%h, need 1 4 4444 1111",
               full, count, or_out, out_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 16'h0, 1, 0);
      checks++;
      if (out_data !== heads[i] || count !== 3'(3 - i) || full !== 1'b0) begin
        errors++;
        $display("FAIL drain_%0d: data=%h count=%0d full=%b, need %h %0d 0",
                 i, out_data, count, full, heads[i], 3 - i);
      end
    end
    tick(0, 16'h0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 16'h0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b count=%0d data=%h, need 0 0 0",
               out_valid, count, out_data);
    end
    // out_ready while empty must not move anything
    tick(0, 16'h0, 1, 0);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_ready: count=%0d valid=%b, need 0 0", count, out_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill4();
    tick(1, 16'hDEAD, 0, 0);
    checks++;
    if (count !== 3'd4 || or_out !== 16'h4444 || overflow !== 1'b1 || out_data !== 16'h1111) begin
      errors++;
      $display("FAIL ovf_drop: count=%0d or=%h ovf=%b data=%h, need 4 4444 1 1111",
               count, or_out, overflow, out_data);
    end
    tick(0, 16'h0, 0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b, need 1", overflow);
    end
    tick(0, 16'h0, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b, need 0", overflow);
    end
    tick(1, 16'hBEEF, 0, 1);
    checks++;
    if (overflow !== 1'b1 || or_out !== 16'h4444 || count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set_wins: ovf=%b or=%h count=%0d, need 1 4444 4",
               overflow, or_out, count);
    end
    // Dropped words must not have overwritten stored entries
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== 16'(16'h1111 * (i + 1))) begin
        errors++;
        $display("FAIL ovf_contents_%0d: data=%h, need %h", i, out_data, 16'h1111 * (i + 1));
      end
      tick(0, 16'h0, 1, 0);
    end
  endtask

  task automatic test_full_pushpop();
    logic [15:0] last;
    do_reset();
    fill4();
    tick(1, 16'h5555, 1, 0);
    checks++;
    if (count !== 3'd4 || out_data !== 16'h2222 || overflow !== 1'b0 || or_out !== 16'h5555 ||
        full !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d data=%h ovf=%b or=%h full=%b, need 4 2222 0 5555 1",
               count, out_data, overflow, or_out, full);
    end
    last = 16'h0;
    for (int i = 0; i < 4; i++) begin
      last = out_data;
      tick(0, 16'h0, 1, 0);
    end
    checks++;
    if (last !== 16'h5555 || count !== 3'd0) begin
      errors++;
      $display("FAIL full_pushpop_last: last=%h count=%0d, need 5555 0", last, count);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] got [$];
    int          maxcnt;
    do_reset();
    maxcnt = 0;
    for (int i = 1; i <= 11; i++) begin
      if (out_valid) got.push_back(out_data);
      if (i <= 10) tick(1, 16'(i), 1, 0);
      else tick(0, 16'h0, 1, 0);
      if (int'(count) > maxcnt) maxcnt = int'(count);
    end
    checks++;
    if (got.size() != 10) begin
      errors++;
      $display("FAIL wrap_size: received=%0d, need 10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++;
      if (got[i] !== 16'(i + 1)) begin
        errors++;
        $display("FAIL wrap_word_%0d: got=%h, need %h", i, got[i], i + 1);
      end
    end
    checks++;
    if (maxcnt > 1 || overflow !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_state: maxcount=%0d ovf=%b count=%0d, need <=1 0 0",
               maxcnt, overflow, count);
    end
  endtask

  task automatic test_empty_latency();
    do_reset();
    tick(1, 16'hBEEF, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || count !== 3'd1) begin
      errors++;
      $display("FAIL latency_push: valid=%b data=%h count=%0d, need 1 beef 1",
               out_valid, out_data, count);
    end
    tick(0, 16'h0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL latency_pop: valid=%b count=%0d, need 0 0", out_valid, count);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_pushpop();
    test_wrap();
    test_empty_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
